// File: rtl/chacha_pkg.sv
// rtl/chacha_pkg.sv - shared types and constants for the ChaCha20 block sequencer
package chacha_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_ROUND,
    ST_ADD,
    ST_OUT,
    ST_DONE
  } state_t;

  localparam int    CHACHA_ROUNDS  = 20;
  localparam word_t CHACHA_CTR_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/chacha_round_ctr.sv
// rtl/chacha_round_ctr.sv - round index counter; flags the last round and column/diagonal parity
module chacha_round_ctr #(
  parameter int ROUNDS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last,
  output logic diag
);

  localparam int IW = $clog2(ROUNDS);

  logic [IW-1:0] r_idx;

  // Index parks on the last round so it never wraps past ROUNDS-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (clr) begin
      r_idx <= '0;
    end else if (en && !last) begin
      r_idx <= r_idx + IW'(1);
    end
  end

  assign last = (r_idx == IW'(ROUNDS - 1));
  assign diag = r_idx[0];

endmodule

// File: rtl/chacha_block_ctrl.sv
// rtl/chacha_block_ctrl.sv - ChaCha20 block sequencer: clear/load/rounds/add/output for a run of blocks
// Optional abort input enabled by defining CHACHA_BLOCK_ABORT_EN.
module chacha_block_ctrl
  import chacha_pkg::*;
#(
  parameter int ROUNDS = CHACHA_ROUNDS,
  parameter int NB_W   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  word_t           init_ctr,
  input  logic [NB_W-1:0] num_blocks,
`ifdef CHACHA_BLOCK_ABORT_EN
  input  logic            abort,
`endif
  output logic            ready,
  output logic            clr_matrix,
  output logic            load_state,
  output word_t           block_ctr,
  output logic            qr_en,
  output logic            qr_diag,
  output logic            add_en,
  output logic            ks_valid,
  input  logic            ks_ready,
  output logic            done,
  output logic            ctr_err
);

  state_t          r_state;
  state_t          w_state_nxt;
  word_t           r_block_ctr;
  logic [NB_W-1:0] r_remaining;
  logic            w_last;
  logic            w_diag;
  logic            w_hs;
  logic            w_ctr_err_nxt;

  logic r_ready, r_clr, r_load, r_qr_en, r_qr_diag, r_add, r_ks_valid, r_done, r_ctr_err;

`ifdef CHACHA_BLOCK_ABORT_EN
  logic r_abort_pend;
`endif

  chacha_round_ctr #(
    .ROUNDS(ROUNDS)
  ) u_round_ctr (
    .clk (clk),
    .rst (rst),
    .clr (r_state == ST_LOAD),
    .en  (r_state == ST_ROUND),
    .last(w_last),
    .diag(w_diag)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_ctr_err_nxt = 1'b0;
    w_hs          = (r_state == ST_OUT) && ks_ready;
    case (r_state)
      ST_IDLE:  if (start && (num_blocks != '0)) w_state_nxt = ST_CLEAR;
      ST_CLEAR: w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_ROUND;
      ST_ROUND: if (w_last) w_state_nxt = ST_ADD;
      ST_ADD:   w_state_nxt = ST_OUT;
      ST_OUT: begin
        if (ks_ready) begin
          if (r_remaining == NB_W'(1)) begin
            w_state_nxt = ST_DONE;
          end else if (r_block_ctr == CHACHA_CTR_MAX) begin
            w_state_nxt   = ST_DONE;
            w_ctr_err_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
`ifdef CHACHA_BLOCK_ABORT_EN
    if ((r_state == ST_CLEAR) && r_abort_pend) w_state_nxt = ST_IDLE;
    // Abort wins over a same-cycle handshake; an abort during CLEAR reuses that clear pulse.
    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt   = (r_state == ST_CLEAR) ? ST_IDLE : ST_CLEAR;
      w_ctr_err_nxt = 1'b0;
      w_hs          = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_block_ctr <= '0;
      r_remaining <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && (w_state_nxt == ST_CLEAR)) begin
        r_block_ctr <= init_ctr;
        r_remaining <= num_blocks;
      end else if (w_hs) begin
        r_remaining <= r_remaining - NB_W'(1);
        if (w_state_nxt == ST_LOAD) r_block_ctr <= r_block_ctr + 32'd1;
      end
    end
  end

`ifdef CHACHA_BLOCK_ABORT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_abort_pend <= 1'b0;
    end else if (abort && (r_state != ST_IDLE) && (r_state != ST_CLEAR)) begin
      r_abort_pend <= 1'b1;
    end else if (r_state == ST_CLEAR) begin
      r_abort_pend <= 1'b0;
    end
  end
`endif

  // Outputs are registered decodes of the next state, so each lines up with its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready    <= 1'b1;
      r_clr      <= 1'b0;
      r_load     <= 1'b0;
      r_qr_en    <= 1'b0;
      r_qr_diag  <= 1'b0;
      r_add      <= 1'b0;
      r_ks_valid <= 1'b0;
      r_done     <= 1'b0;
      r_ctr_err  <= 1'b0;
    end else begin
      r_ready    <= (w_state_nxt == ST_IDLE);
      r_clr      <= (w_state_nxt == ST_CLEAR);
      r_load     <= (w_state_nxt == ST_LOAD);
      r_qr_en    <= (w_state_nxt == ST_ROUND);
      r_qr_diag  <= (w_state_nxt == ST_ROUND) && (r_state == ST_ROUND) && !w_diag;
      r_add      <= (w_state_nxt == ST_ADD);
      r_ks_valid <= (w_state_nxt == ST_OUT);
      r_done     <= (w_state_nxt == ST_DONE);
      r_ctr_err  <= w_ctr_err_nxt;
    end
  end

  assign ready      = r_ready;
  assign clr_matrix = r_clr;
  assign load_state = r_load;
  assign block_ctr  = r_block_ctr;
  assign qr_en      = r_qr_en;
  assign qr_diag    = r_qr_diag;
  assign add_en     = r_add;
  assign ks_valid   = r_ks_valid;
  assign done       = r_done;
  assign ctr_err    = r_ctr_err;

endmodule

// File: doc/chacha_block_ctrl.md
# chacha_block_ctrl

Sequencing controller for the ChaCha20 block function. It drives the state-matrix builder's clear, load and block-counter inputs, steps the quarter-round datapath through column and diagonal rounds, and commands the final feed-forward add. It then presents each finished 64-byte keystream block through a valid/ready handshake, for a requested run of consecutive blocks. It sits between the AEAD top-level (key/nonce setup, Poly1305 key generation, encryption stream) and the state/quarter-round datapath.

## Interface
- ROUNDS, default 20: rounds per block. Must be even and ≥2; one double round is a column round plus a diagonal round.
- NB_W, default 16: width of the block-count request.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a run; sampled only in IDLE
- init_ctr  in  32  first block-counter value (word_t); captured on accepted start
- num_blocks  in  NB_W  blocks in the run; captured on accepted start
- ready  out  1  high only in IDLE
- clr_matrix  out  1  one-cycle clear to the state builder
- load_state  out  1  one-cycle load of the working state from the state builder
- block_ctr  out  32  Block input to the state builder
- qr_en  out  1  quarter-round datapath advances one round this cycle
- qr_diag  out  1  0 = column round, 1 = diagonal round
- add_en  out  1  one-cycle feed-forward add (working state + initial state)
- ks_valid  out  1  keystream block available
- ks_ready  in  1  consumer accepts the keystream block
- done  out  1  one-cycle pulse when the run ends
- ctr_err  out  1  one-cycle pulse, coincident with done, on counter exhaustion

## Operation
- The FSM states are IDLE, CLEAR, LOAD, ROUND, ADD, OUT and DONE.
- IDLE: if start=1 and num_blocks≠0, capture init_ctr into block_ctr, load the remaining count, and go to CLEAR. start with num_blocks=0 is ignored: the block stays in IDLE with no done pulse.
- CLEAR: 1 cycle, clr_matrix=1, then go to LOAD.
- LOAD: 1 cycle, load_state=1. block_ctr is valid and stable. Clear the round index and go to ROUND.
- ROUND: exactly ROUNDS cycles with qr_en=1 and qr_diag=round_idx[0] (first round is a column round). After the last round, go to ADD.
- ADD: 1 cycle, add_en=1, then go to OUT.
- OUT: ks_valid=1 and block_ctr is held until ks_ready=1. On handshake, decrement remaining:
  - If remaining was 1, go to DONE.
  - Else, if block_ctr=32'hFFFF_FFFF, go to DONE with ctr_err (the counter never wraps).
  - Else, increment block_ctr and go to LOAD. No CLEAR between blocks.
- DONE: 1 cycle, done=1 (and ctr_err=1 if flagged), then go to IDLE.
- start in any state other than IDLE is ignored. init_ctr and num_blocks are not re-sampled mid-run.
- Every control output is a registered Moore function of state. All pulses are exactly one cycle wide.

## Timing
- Reset values: state=IDLE, ready=1, block_ctr=0, round_idx=0, remaining=0. All other outputs are 0.
- Reset asserted mid-run returns to IDLE immediately. No done pulse; ks_valid drops asynchronously.
- First block: start sampled at edge 0, giving CLEAR in cycle 1, LOAD in cycle 2, ROUND in cycles 3..ROUNDS+2, and ADD in cycle ROUNDS+3. ks_valid rises in cycle ROUNDS+4 (24 for ROUNDS=20).
- Subsequent blocks: ks_valid rises ROUNDS+3 cycles after the handshake edge (23 for ROUNDS=20).
- ks_ready held high gives zero stall. A consumer stall only extends OUT.
- done appears the cycle after the final handshake. ready returns the cycle after that.

## Configuration
- CHACHA_BLOCK_ABORT_EN defined:
  - Adds input abort (1 bit).
  - abort=1 in any non-IDLE state goes to CLEAR-then-IDLE: one clr_matrix pulse, no done, no ctr_err.
  - abort has priority over the ks_ready handshake in the same cycle.
- CHACHA_BLOCK_ABORT_EN undefined: the port is absent and a run can only be ended by completion or rst.

## Structure
- Shared package chacha_pkg holds:
  - word_t (32-bit logic)
  - the FSM state enum
  - CHACHA_ROUNDS (default 20)
  - the constant CHACHA_CTR_MAX = 32'hFFFF_FFFF
- One sub-module, chacha_round_ctr, holds the round index counter. Its interface:
  - inputs clr and en
  - outputs last (index = ROUNDS-1) and diag (index[0])
- The FSM, block counter and remaining-block counter live in chacha_block_ctrl.

## Test plan
- Reset, then no stimulus: ready=1, all other outputs 0, block_ctr=0.
- start, init_ctr=1, num_blocks=1, ks_ready=1: clr_matrix in cycle 1, load_state in cycle 2, 20 qr_en cycles alternating qr_diag 0/1 starting at 0, add_en in cycle 23, ks_valid in cycle 24 with block_ctr=1, done in cycle 25.
- num_blocks=3, init_ctr=7, with ks_ready low for 5 cycles on block 2: block_ctr is 7, 8, 9 on the successive ks_valid windows; the inter-block gap is 23 cycles plus the stall; exactly one done.
- init_ctr=32'hFFFF_FFFE, num_blocks=4: two blocks delivered (…FE, …FF), then done and ctr_err pulse together, and block_ctr never wraps to 0.
- num_blocks=0 with start, and start pulsed while in ROUND: both ignored, with no state or counter change.
- rst pulsed during ROUND (and abort with CHACHA_BLOCK_ABORT_EN): back to IDLE, no done; abort additionally gives exactly one clr_matrix.
